// File: rtl/matrix_cmd_seq.sv
// matrix_cmd_seq: command-side driver for the matrix stack controller.
// Decodes GL-style matrix commands, buffers 4-row payloads, tracks stack depth.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   cmd_valid/cmd_ready   command beat handshake
//   cmd_op, cmd_data      opcode (ignored on payload beats), mode bit or row
//   stall                 downstream full; blocks starting a new issue
//   matrix_mode           0 modelview, 1 projection
//   load_id_en, load_en,
//   pop_en, write_en      single-cycle stack pulses (push_en reserved, 0)
//   data_out              row stream for load (row 0 alongside load_en)
//   write_out_0..3        rows for top-of-stack overwrite
//   depth_mv, depth_pj    current stack depths (1..MAX_DEPTH)
//   err                   pulse on rejected or illegal command
module matrix_cmd_seq #(
  parameter int MAX_DEPTH = 2,
  parameter int ROW_W     = 128
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [ROW_W-1:0] cmd_data,
  input  logic             stall,
  output logic             matrix_mode,
  output logic             load_id_en,
  output logic             load_en,
  output logic             pop_en,
  output logic             push_en,
  output logic             write_en,
  output logic [ROW_W-1:0] data_out,
  output logic [ROW_W-1:0] write_out_0,
  output logic [ROW_W-1:0] write_out_1,
  output logic [ROW_W-1:0] write_out_2,
  output logic [ROW_W-1:0] write_out_3,
  output logic [1:0]       depth_mv,
  output logic [1:0]       depth_pj,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLL_L,
    S_COLL_W,
    S_WAIT_L,
    S_WAIT_W,
    S_ISS_L,
    S_ISS_W
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_MODE = 3'd1;
  localparam logic [2:0] OP_LID  = 3'd2;
  localparam logic [2:0] OP_LOAD = 3'd3;
  localparam logic [2:0] OP_POP  = 3'd4;
  localparam logic [2:0] OP_WR   = 3'd5;

  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q [4];
  logic [ROW_W-1:0] row_d [4];
  logic [ROW_W-1:0] wo_q [4];
  logic [ROW_W-1:0] wo_d [4];
  logic [ROW_W-1:0] dout_q, dout_d;
  logic mode_q, mode_d;
  logic lid_q, lid_d;
  logic ld_q, ld_d;
  logic pop_q, pop_d;
  logic wr_q, wr_d;
  logic err_q, err_d;
  logic [1:0] dmv_q, dmv_d;
  logic [1:0] dpj_q, dpj_d;

  logic acc;
  logic [1:0] cur_depth;
  logic full;

  // Ready is gated by reset_n so nothing is taken while reset is held.
  always_comb begin
    cmd_ready = 1'b0;
    unique case (state_q)
      S_IDLE:   cmd_ready = !stall;
      S_COLL_L: cmd_ready = 1'b1;
      S_COLL_W: cmd_ready = 1'b1;
      default:  cmd_ready = 1'b0;
    endcase
    cmd_ready = cmd_ready & reset_n;
  end

  assign acc       = cmd_valid & cmd_ready;
  assign cur_depth = mode_q ? dpj_q : dmv_q;
  assign full      = (cur_depth == 2'(MAX_DEPTH));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    wo_d    = wo_q;
    dout_d  = dout_q;
    mode_d  = mode_q;
    lid_d   = 1'b0;
    ld_d    = 1'b0;
    pop_d   = 1'b0;
    wr_d    = 1'b0;
    err_d   = 1'b0;
    dmv_d   = dmv_q;
    dpj_d   = dpj_q;
    unique case (state_q)
      S_IDLE: begin
        if (acc) begin
          unique case (cmd_op)
            OP_NOP:  ;
            OP_MODE: mode_d = cmd_data[0];
            OP_LID:  lid_d = 1'b1;
            OP_LOAD: begin
              row_d[0] = cmd_data;
              cnt_d    = 2'd1;
              state_d  = S_COLL_L;
            end
            OP_POP: begin
              if (cur_depth == 2'd1) begin
                err_d = 1'b1;
              end else begin
                pop_d = 1'b1;
                if (mode_q) dpj_d = dpj_q - 2'd1;
                else        dmv_d = dmv_q - 2'd1;
              end
            end
            OP_WR: begin
              row_d[0] = cmd_data;
              cnt_d    = 2'd1;
              state_d  = S_COLL_W;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_COLL_L, S_COLL_W: begin
        if (acc) begin
          row_d[cnt_q] = cmd_data;
          cnt_d        = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (state_q == S_COLL_W) begin
              state_d = S_WAIT_W;
            end else if (full) begin
              // Overflowing load: payload drained, nothing issued.
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_WAIT_L;
            end
          end
        end
      end
      S_WAIT_L: begin
        if (!stall) begin
          state_d = S_ISS_L;
          cnt_d   = 2'd0;
          ld_d    = 1'b1;
          dout_d  = row_q[0];
          if (mode_q) dpj_d = dpj_q + 2'd1;
          else        dmv_d = dmv_q + 2'd1;
        end
      end
      S_ISS_L: begin
        // cnt_q is the row currently on data_out.
        if (cnt_q == 2'd3) begin
          state_d = S_IDLE;
        end else begin
          dout_d = row_q[cnt_q + 2'd1];
          cnt_d  = cnt_q + 2'd1;
        end
      end
      S_WAIT_W: begin
        if (!stall) begin
          state_d = S_ISS_W;
          wr_d    = 1'b1;
          wo_d    = row_q;
        end
      end
      S_ISS_W: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        row_q[i] <= '0;
        wo_q[i]  <= '0;
      end
      dout_q  <= '0;
      mode_q  <= 1'b0;
      lid_q   <= 1'b0;
      ld_q    <= 1'b0;
      pop_q   <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      dmv_q   <= 2'd1;
      dpj_q   <= 2'd1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      wo_q    <= wo_d;
      dout_q  <= dout_d;
      mode_q  <= mode_d;
      lid_q   <= lid_d;
      ld_q    <= ld_d;
      pop_q   <= pop_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      dmv_q   <= dmv_d;
      dpj_q   <= dpj_d;
    end
  end

  assign matrix_mode = mode_q;
  assign load_id_en  = lid_q;
  assign load_en     = ld_q;
  assign pop_en      = pop_q;
  assign push_en     = 1'b0;
  assign write_en    = wr_q;
  assign data_out    = dout_q;
  assign write_out_0 = wo_q[0];
  assign write_out_1 = wo_q[1];
  assign write_out_2 = wo_q[2];
  assign write_out_3 = wo_q[3];
  assign depth_mv    = dmv_q;
  assign depth_pj    = dpj_q;
  assign err         = err_q;

endmodule

// File: tb/tb_matrix_cmd_seq.sv
// tb_matrix_cmd_seq: directed plus random command bench for matrix_cmd_seq.
// A command-level model predicts pulse counts, depths, load rows and write rows.
module tb_matrix_cmd_seq;

  localparam int W    = 128;
  localparam int MAXD = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = 3'd0;
  logic [W-1:0] cmd_data = '0;
  logic         stall = 1'b0;
  logic         matrix_mode;
  logic         load_id_en, load_en, pop_en, push_en, write_en;
  logic [W-1:0] data_out;
  logic [W-1:0] write_out_0, write_out_1, write_out_2, write_out_3;
  logic [1:0]   depth_mv, depth_pj;
  logic         err;

  matrix_cmd_seq #(.MAX_DEPTH(MAXD), .ROW_W(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .stall(stall),
    .matrix_mode(matrix_mode), .load_id_en(load_id_en),
    .load_en(load_en), .pop_en(pop_en), .push_en(push_en),
    .write_en(write_en), .data_out(data_out),
    .write_out_0(write_out_0), .write_out_1(write_out_1),
    .write_out_2(write_out_2), .write_out_3(write_out_3),
    .depth_mv(depth_mv), .depth_pj(depth_pj), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // model state
  int m_mode = 0;
  int m_depth [2] = '{1, 1};
  int e_lid = 0, e_ld = 0, e_pop = 0, e_wr = 0, e_err = 0;
  logic [W-1:0] e_rows [$];
  logic [W-1:0] e_wo [4];

  // observed
  int n_lid = 0, n_ld = 0, n_pop = 0, n_wr = 0, n_err = 0;
  int win = 0;
  logic [W-1:0] o_rows [$];

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      win = 0;
    end else begin
      chk("onehot", W'($countones({load_id_en, load_en, pop_en, write_en}) <= 1), W'(1));
      chk("push_en", W'(push_en), W'(0));
      if (load_id_en) n_lid++;
      if (load_en) begin n_ld++; win = 4; end
      if (pop_en) n_pop++;
      if (write_en) n_wr++;
      if (err) n_err++;
      if (win > 0) begin
        o_rows.push_back(data_out);
        chk("ready_in_issue", W'(cmd_ready), W'(0));
        win--;
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] d);
    int n;
    logic ok;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    forever begin
      #1 ok = cmd_ready;
      @(posedge clk);
      if (ok) break;
      n++;
      if (n > 100) begin
        total++; bad++;
        $error("FAIL send_timeout observed=not_accepted expected=accepted");
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic model(input logic [2:0] op, input logic [W-1:0] r [4]);
    case (op)
      3'd1: m_mode = int'(r[0][0]);
      3'd2: e_lid++;
      3'd3: if (m_depth[m_mode] == MAXD) e_err++;
            else begin
              e_ld++; m_depth[m_mode]++;
              for (int i = 0; i < 4; i++) e_rows.push_back(r[i]);
            end
      3'd4: if (m_depth[m_mode] == 1) e_err++;
            else begin e_pop++; m_depth[m_mode]--; end
      3'd5: begin e_wr++; e_wo = r; end
      3'd6, 3'd7: e_err++;
      default: ;
    endcase
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] r [4],
                        input int gap, input int hold);
    send(op, r[0]);
    if (op == 3'd3 || op == 3'd5) begin
      for (int b = 1; b < 4; b++) begin
        if (gap > 0) idle($urandom_range(gap, 0));
        if (b == 3 && hold > 0) stall = 1'b1;
        send(3'($urandom_range(7, 0)), r[b]);
      end
      if (hold > 0) begin
        idle(hold);
        stall = 1'b0;
      end
    end
    model(op, r);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_lid"}, W'(n_lid), W'(e_lid));
    chk({tag, "_ld"}, W'(n_ld), W'(e_ld));
    chk({tag, "_pop"}, W'(n_pop), W'(e_pop));
    chk({tag, "_wr"}, W'(n_wr), W'(e_wr));
    chk({tag, "_err"}, W'(n_err), W'(e_err));
    chk({tag, "_dmv"}, W'(depth_mv), W'(m_depth[0]));
    chk({tag, "_dpj"}, W'(depth_pj), W'(m_depth[1]));
    chk({tag, "_mode"}, W'(matrix_mode), W'(m_mode));
  endtask

  task automatic rnd_rows(output logic [W-1:0] r [4]);
    for (int i = 0; i < 4; i++)
      r[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r [4];
    logic [W-1:0] w [4];
    logic [2:0] op;
    int n;

    // reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", W'(cmd_ready), W'(0));
    chk("rst_dmv", W'(depth_mv), W'(1));
    chk("rst_dpj", W'(depth_pj), W'(1));
    chk("rst_mode", W'(matrix_mode), W'(0));
    chk("rst_pulses", W'({load_id_en, load_en, pop_en, write_en, err}), W'(0));
    chk("rst_dout", data_out, W'(0));
    chk("rst_wo0", write_out_0, W'(0));
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ready_after_rst", W'(cmd_ready), W'(1));

    // identity-ish rows, back-to-back beats
    r[0] = 128'h3F800000_00000000_00000000_00000000;
    r[1] = 128'h00000000_3F800000_00000000_00000000;
    r[2] = 128'h00000000_00000000_3F800000_00000000;
    r[3] = 128'h00000000_00000000_00000000_3F800000;
    do_cmd(3'd3, r, 0, 0);
    tick();
    chk("t1_wait_ld", W'(load_en), W'(0));
    chk("t1_wait_rdy", W'(cmd_ready), W'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_ld", W'(load_en), W'(i == 0));
      chk("t1_row", data_out, r[i]);
      chk("t1_rdy", W'(cmd_ready), W'(0));
    end
    chk("t1_dmv", W'(depth_mv), W'(2));
    tick();
    chk("t1_rdy_back", W'(cmd_ready), W'(1));
    chk_state("t1");

    // overflow
    rnd_rows(r);
    do_cmd(3'd3, r, 0, 0);
    tick();
    chk("t2_err", W'(err), W'(1));
    chk("t2_ld", W'(load_en), W'(0));
    tick();
    chk("t2_err_off", W'(err), W'(0));
    idle(6);
    chk_state("t2");

    // projection mode, underflow pop, load, pop
    r[0] = W'(1);
    do_cmd(3'd1, r, 0, 0);
    tick();
    chk("t3_mode", W'(matrix_mode), W'(1));
    do_cmd(3'd4, r, 0, 0);
    tick();
    chk("t3_uf_err", W'(err), W'(1));
    chk("t3_uf_pop", W'(pop_en), W'(0));
    chk("t3_dpj1", W'(depth_pj), W'(1));
    rnd_rows(r);
    do_cmd(3'd3, r, 2, 0);
    idle(8);
    chk("t3_dpj2", W'(depth_pj), W'(2));
    do_cmd(3'd4, r, 0, 0);
    tick();
    chk("t3_pop", W'(pop_en), W'(1));
    chk("t3_dpj_back", W'(depth_pj), W'(1));
    tick();
    chk("t3_pop_off", W'(pop_en), W'(0));
    chk_state("t3");

    // write with gaps and a 5-cycle stall after the last beat
    rnd_rows(w);
    send(3'd5, w[0]);
    idle(2);
    send(3'd2, w[1]);
    idle(1);
    send(3'd7, w[2]);
    idle(3);
    stall = 1'b1;
    send(3'd4, w[3]);
    model(3'd5, w);
    repeat (5) begin
      tick();
      chk("t4_stalled", W'(write_en), W'(0));
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    chk("t4_pre", W'(write_en), W'(0));
    tick();
    chk("t4_wr", W'(write_en), W'(1));
    chk("t4_wo0", write_out_0, w[0]);
    chk("t4_wo1", write_out_1, w[1]);
    chk("t4_wo2", write_out_2, w[2]);
    chk("t4_wo3", write_out_3, w[3]);
    tick();
    chk("t4_wr_off", W'(write_en), W'(0));
    chk("t4_rdy", W'(cmd_ready), W'(1));

    // stall raised mid-issue
    rnd_rows(r);
    do_cmd(3'd3, r, 1, 0);
    tick();
    tick();
    chk("t5_ld", W'(load_en), W'(1));
    chk("t5_r0", data_out, r[0]);
    tick();
    chk("t5_r1", data_out, r[1]);
    stall = 1'b1;
    tick();
    chk("t5_r2", data_out, r[2]);
    tick();
    chk("t5_r3", data_out, r[3]);
    stall = 1'b0;
    chk("t5_dpj", W'(depth_pj), W'(2));
    rnd_rows(r);
    do_cmd(3'd7, r, 0, 0);
    tick();
    chk("t5_ill_err", W'(err), W'(1));
    chk("t5_ill_quiet", W'({load_id_en, load_en, pop_en, write_en}), W'(0));
    tick();
    chk_state("t5");

    // reset between load beats 1 and 2
    rnd_rows(r);
    send(3'd3, r[0]);
    send(3'd0, r[1]);
    @(negedge clk);
    cmd_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_rdy", W'(cmd_ready), W'(0));
    m_mode = 0;
    m_depth = '{1, 1};
    @(negedge clk);
    reset_n = 1'b1;
    do_cmd(3'd2, r, 0, 0);
    tick();
    chk("t6_lid", W'(load_id_en), W'(1));
    idle(10);
    chk("t6_dmv", W'(depth_mv), W'(1));
    chk_state("t6");

    // random commands
    for (int k = 0; k < 60; k++) begin
      op = 3'($urandom_range(7, 0));
      rnd_rows(r);
      if ($urandom_range(3, 0) == 0) begin
        stall = 1'b1;
        tick();
        chk("rnd_idle_stall", W'(cmd_ready), W'(0));
        stall = 1'b0;
      end
      do_cmd(op, r, $urandom_range(2, 0), $urandom_range(4, 0));
      idle(10);
      chk_state("rnd");
      if (op == 3'd5) begin
        chk("rnd_wo0", write_out_0, e_wo[0]);
        chk("rnd_wo1", write_out_1, e_wo[1]);
        chk("rnd_wo2", write_out_2, e_wo[2]);
        chk("rnd_wo3", write_out_3, e_wo[3]);
      end
    end

    chk("rows_count", W'(o_rows.size()), W'(e_rows.size()));
    n = (o_rows.size() < e_rows.size()) ? o_rows.size() : e_rows.size();
    for (int i = 0; i < n; i++) chk("rows", o_rows[i], e_rows[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_cmd_seq.md
Name: matrix_cmd_seq

Overview:
- Command-side driver for the matrix stack controller.
- Accepts GL-style matrix commands (mode select, load identity, load matrix, pop, write-back) from the upstream command FIFO over a valid/ready handshake.
- Buffers multi-beat payloads, tracks per-mode stack depth to reject overflow/underflow, and issues the pulse/row sequence the stack expects: load_en then 3 consecutive row cycles, single-cycle load_id_en/pop_en/write_en.

Parameters:
- MAX_DEPTH, 2, matrices per stack (modelview and projection each).
- ROW_W, 128, bits per matrix row (4 x fp32).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command beat valid
- cmd_ready  output  1  command beat accepted when valid&ready
- cmd_op  input  3  0 NOP, 1 MODE, 2 LOAD_ID, 3 LOAD, 4 POP, 5 WRITE, 6-7 illegal (ignored on payload beats)
- cmd_data  input  ROW_W  MODE: bit0 = mode; LOAD/WRITE: row payload
- stall  input  1  downstream fifo_full; blocks starting a new issue
- matrix_mode  output  1  0 modelview, 1 projection
- load_id_en  output  1  identity-load pulse
- load_en  output  1  load-start pulse (row 0 on data_out)
- pop_en  output  1  pop pulse
- push_en  output  1  tied 0 (reserved)
- write_en  output  1  top-of-stack overwrite pulse
- data_out  output  ROW_W  row stream for load
- write_out_0..write_out_3  output  ROW_W each  rows 0-3 for write-back
- depth_mv, depth_pj  output  2 each  current stack depth, 1..MAX_DEPTH
- err  output  1  one-cycle pulse on rejected or illegal command

Behaviour:
- Reset (async, reset_n=0):
  - All pulses, err and data/write outputs = 0; matrix_mode = 0; depth_mv = depth_pj = 1.
  - FSM = IDLE; cmd_ready = 0 while reset_n = 0, and 1 in IDLE after release.
  - Reset mid-collect or mid-issue aborts silently; no partial sequence resumes.
- All outputs registered. Command accepted in cycle N produces its output pulse in cycle N+1.
- FSM states:
  - IDLE: cmd_ready = !stall.
    - NOP: consumed, no output.
    - MODE: matrix_mode <= cmd_data[0].
    - LOAD_ID: load_id_en pulse.
    - POP: pop_en pulse and depth-1 for the current mode. If depth==1: no pop_en, err pulse.
    - LOAD: beat 0 latched into row buffer, go to COLLECT_L.
    - WRITE: beat 0 latched, go to COLLECT_W.
    - Illegal op: consumed, err pulse.
  - COLLECT_L / COLLECT_W: cmd_ready = 1; rows 1-3 captured on the next 3 accepted beats, cmd_op ignored. Gaps (cmd_valid=0) allowed. After row 3 go to WAIT.
  - WAIT: cmd_ready = 0; hold until stall = 0, then enter ISSUE_L or ISSUE_W in the next cycle.
  - ISSUE_L: 4 consecutive cycles with data_out = row0, row1, row2, row3; load_en = 1 only in the first. Stall is ignored once issue has begun. depth+1 for the current mode. Then IDLE.
  - ISSUE_W: one cycle, write_en = 1, write_out_0..3 = rows 0..3. Then IDLE.
- Overflow: LOAD with depth==MAX_DEPTH still consumes all 4 beats, but no issue occurs; err pulses after the 4th beat.
- matrix_mode cannot change during COLLECT/WAIT/ISSUE; the mode latched at command start applies to depth accounting.
- cmd_ready = 0 during ISSUE_L and ISSUE_W. At most one of load_id_en/load_en/pop_en/write_en is high in any cycle.
- data_out holds its last value outside ISSUE_L; write_out_* holds its last value outside ISSUE_W.

Test Plan:
- Reset, then LOAD with rows 3F800000_0..0, 0..3F800000_0..0, 0..3F800000_0, 0..3F800000 back-to-back -> load_en high for 1 cycle, data_out rows in 4 consecutive cycles in order, depth_mv = 2, cmd_ready low for those 4 cycles.
- LOAD with depth_mv = 2 -> 4 beats consumed, no load_en, err pulses once, depth_mv stays 2.
- MODE(1), POP at depth_pj = 1 -> err pulse, no pop_en. Then LOAD, then POP -> depth_pj goes 1 -> 2 -> 1 and pop_en pulses once.
- WRITE with 4 beats with cmd_valid gaps, stall = 1 for 5 cycles after beat 3 -> write_en stays 0 until the cycle after stall drops. Then write_en pulses exactly once with write_out_0..3 equal to beats 0..3.
- Stall raised during ISSUE_L row 1 -> rows 2 and 3 still issued on consecutive cycles. Illegal op 7 -> err pulse, no other output.
- Assert reset_n = 0 between LOAD beats 1 and 2, release, send LOAD_ID -> no load_en ever appears, load_id_en pulses, depth_mv = 1.
